// File: rtl/somatic_sensor_hub_pkg.sv
// Shared constants and helpers for the somatic input interface.
// Also consumed by the circadian_controller integration.
package banos_somatic_pkg;

    localparam int SPIKE_CNT_W = 32;
    localparam int ENTROPY_W   = 16;

    // Clamp a wide unsigned value to 16 bits.
    function automatic logic [15:0] sat16(input logic [31:0] v);
        return (v > 32'h0000_FFFF) ? 16'hFFFF : v[15:0];
    endfunction

    // Population count over up to 16 lanes; unused lanes must be zero.
    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] c;
        c = '0;
        for (int i = 0; i < 16; i++) c = c + 5'(v[i]);
        return c;
    endfunction

endpackage

// File: rtl/somatic_sensor_hub_thermal_ema.sv
// Thermal heat proxy: baseline deviation, EMA smoothing, sensor stale
// detection and re-seed after a stale period.
module thermal_ema
    import banos_somatic_pkg::*;
#(
    parameter int                TEMP_W        = 12,
    parameter logic [TEMP_W-1:0] TEMP_BASELINE = 12'd2048,
    parameter int                EMA_SHIFT     = 3,
    parameter int                STALE_WINDOWS = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_temp_valid,
    input  logic [TEMP_W-1:0] i_temp_data,
    input  logic              i_window_tick,
    output logic [15:0]       o_thermal_term,
    output logic              o_sensor_stale
);

    localparam int SC_W = $clog2(STALE_WINDOWS + 1);

    logic [15:0]        r_ema;
    logic               r_stale;
    logic [SC_W-1:0]    r_stale_cnt;

    logic [TEMP_W-1:0]  w_dev;
    logic [15:0]        w_dev16;
    logic signed [17:0] w_diff;
    logic signed [17:0] w_step;
    logic signed [17:0] w_sum;
    logic [15:0]        w_ema_next;

    assign w_dev   = (i_temp_data >= TEMP_BASELINE) ? (i_temp_data - TEMP_BASELINE)
                                                    : (TEMP_BASELINE - i_temp_data);
    assign w_dev16 = 16'(w_dev) << (16 - TEMP_W);

    // Signed difference with headroom so the arithmetic shift floors correctly.
    assign w_diff = $signed({2'b00, w_dev16}) - $signed({2'b00, r_ema});
    assign w_step = w_diff >>> EMA_SHIFT;
    assign w_sum  = $signed({2'b00, r_ema}) + w_step;

    // Clamp the smoothed value into the unsigned 16-bit range.
    always_comb begin
        w_ema_next = w_sum[15:0];
        if (w_sum[17])      w_ema_next = 16'h0000;
        else if (w_sum[16]) w_ema_next = 16'hFFFF;
    end

    // EMA update and stale tracking; a fresh sample always beats the stale assert.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ema       <= '0;
            r_stale     <= 1'b0;
            r_stale_cnt <= '0;
        end else if (i_temp_valid) begin
            r_ema       <= r_stale ? w_dev16 : w_ema_next;
            r_stale     <= 1'b0;
            r_stale_cnt <= '0;
        end else if (i_window_tick && !r_stale) begin
            if (r_stale_cnt == SC_W'(STALE_WINDOWS - 1)) r_stale <= 1'b1;
            r_stale_cnt <= r_stale_cnt + SC_W'(1);
        end
    end

    // Fail hot while the feed is lost so the controller leans toward sleep.
    assign o_thermal_term = r_stale ? 16'hFFFF : r_ema;
    assign o_sensor_stale = r_stale;

endmodule

// File: rtl/somatic_sensor_hub.sv
// Somatic sensor hub: spike activity counting, windowed spike rate and
// combined heat/activity entropy for the circadian controller.
module somatic_sensor_hub
    import banos_somatic_pkg::*;
#(
    parameter int                LANES         = 8,
    parameter int                TEMP_W        = 12,
    parameter logic [TEMP_W-1:0] TEMP_BASELINE = 12'd2048,
    parameter int                WINDOW_BITS   = 20,
    parameter int                EMA_SHIFT     = 3,
    parameter int                STALE_WINDOWS = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [LANES-1:0]       i_spike_in,
    input  logic                   i_temp_valid,
    input  logic [TEMP_W-1:0]      i_temp_data,
    input  logic                   i_clear_counts,
    output logic [SPIKE_CNT_W-1:0] o_total_spikes,
    output logic [ENTROPY_W-1:0]   o_current_entropy,
    output logic [15:0]            o_spike_rate,
    output logic                   o_window_tick,
    output logic                   o_sensor_stale
);

    logic [4:0]             r_pop;
    logic [SPIKE_CNT_W-1:0] r_total;
    logic [WINDOW_BITS-1:0] r_win_cnt;
    logic [15:0]            r_win_acc;
    logic [15:0]            r_rate;
    logic                   r_tick;
    logic [ENTROPY_W-1:0]   r_entropy;

    logic                   w_wrap;
    logic [15:0]            w_thermal;

    assign w_wrap = &r_win_cnt;

    // Stage 1: lane popcount; a clear discards this cycle's spikes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              r_pop <= '0;
        else if (i_clear_counts) r_pop <= '0;
        else                     r_pop <= popcount16(16'(i_spike_in));
    end

    // Stage 2: cumulative count, wraps modulo 2^32 by design.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              r_total <= '0;
        else if (i_clear_counts) r_total <= '0;
        else                     r_total <= r_total + SPIKE_CNT_W'(r_pop);
    end

    // Free-running window counter; the clear request leaves it alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_win_cnt <= '0;
        else        r_win_cnt <= r_win_cnt + WINDOW_BITS'(1);
    end

    // Window accumulation, rate publish and tick; clear beats the publish.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_win_acc <= '0;
            r_rate    <= '0;
            r_tick    <= 1'b0;
        end else begin
            r_tick <= w_wrap;
            if (i_clear_counts) begin
                r_win_acc <= '0;
                r_rate    <= '0;
            end else if (w_wrap) begin
                r_rate    <= sat16(32'(r_win_acc) + 32'(r_pop));
                r_win_acc <= '0;
            end else begin
                r_win_acc <= sat16(32'(r_win_acc) + 32'(r_pop));
            end
        end
    end

    thermal_ema #(
        .TEMP_W        (TEMP_W),
        .TEMP_BASELINE (TEMP_BASELINE),
        .EMA_SHIFT     (EMA_SHIFT),
        .STALE_WINDOWS (STALE_WINDOWS)
    ) u_thermal (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_temp_valid   (i_temp_valid),
        .i_temp_data    (i_temp_data),
        .i_window_tick  (r_tick),
        .o_thermal_term (w_thermal),
        .o_sensor_stale (o_sensor_stale)
    );

    // Entropy combines heat with a quarter of the published spike rate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_entropy <= '0;
        else        r_entropy <= sat16(32'(w_thermal) + 32'(r_rate >> 2));
    end

    assign o_total_spikes    = r_total;
    assign o_current_entropy = r_entropy;
    assign o_spike_rate      = r_rate;
    assign o_window_tick     = r_tick;

endmodule

// File: tb/tb_somatic_sensor_hub.sv
// Self-checking bench for somatic_sensor_hub: directed scenarios plus
// randomized traffic against a behavioural model.
module tb_somatic_sensor_hub;

    localparam int LANES = 8;
    localparam int TW    = 12;
    localparam int WB    = 4;
    localparam int WLEN  = 1 << WB;
    localparam int BASE  = 2048;
    localparam int ESH   = 3;
    localparam int STALE = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [LANES-1:0] spk = '0;
    logic             tv = 1'b0;
    logic [TW-1:0]    temp = '0;
    logic             clr = 1'b0;
    logic [31:0]      o_total;
    logic [15:0]      o_ent;
    logic [15:0]      o_rate;
    logic             o_tick;
    logic             o_stale;

    int n_chk = 0;
    int n_fail = 0;

    somatic_sensor_hub #(
        .LANES(LANES), .TEMP_W(TW), .TEMP_BASELINE(12'd2048),
        .WINDOW_BITS(WB), .EMA_SHIFT(ESH), .STALE_WINDOWS(STALE)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_spike_in(spk), .i_temp_valid(tv),
        .i_temp_data(temp), .i_clear_counts(clr),
        .o_total_spikes(o_total), .o_current_entropy(o_ent),
        .o_spike_rate(o_rate), .o_window_tick(o_tick), .o_sensor_stale(o_stale)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Behavioural model: quantities as the rules describe them, in plain ints.
    longint m_total;
    int     m_s1;      // spikes seen last cycle, not yet in the total
    int     m_win, m_rate, m_ema, m_since, m_ent;
    bit     m_tick, m_stale;
    int     m_edges;   // clock edges since reset release

    task automatic model_reset();
        m_total = 0; m_s1 = 0; m_win = 0; m_rate = 0; m_ema = 0;
        m_since = 0; m_ent = 0; m_tick = 0; m_stale = 0; m_edges = 0;
    endtask

    function automatic int cap16(input int v);
        return (v > 65535) ? 65535 : v;
    endfunction

    task automatic model_step();
        int  prev, heat, ent_n, dev, d, q;
        bit  last_of_window;
        prev  = m_s1;
        heat  = m_stale ? 65535 : m_ema;
        ent_n = cap16(heat + m_rate / 4);
        last_of_window = (m_edges % WLEN) == (WLEN - 1);
        if (clr) begin
            m_total = 0; m_win = 0; m_rate = 0; m_s1 = 0;
        end else begin
            m_s1    = $countones(spk);
            m_total = (m_total + prev) & 64'hFFFF_FFFF;
            if (last_of_window) begin
                m_rate = cap16(m_win + prev);
                m_win  = 0;
            end else begin
                m_win = cap16(m_win + prev);
            end
        end
        if (tv) begin
            dev = (int'(temp) >= BASE) ? int'(temp) - BASE : BASE - int'(temp);
            dev = dev * (1 << (16 - TW));
            if (m_stale) m_ema = dev;
            else begin
                d = dev - m_ema;
                q = d / (1 << ESH);
                if (d < 0 && (d % (1 << ESH)) != 0) q = q - 1;
                m_ema = m_ema + q;
                if (m_ema < 0) m_ema = 0;
                m_ema = cap16(m_ema);
            end
            m_stale = 0; m_since = 0;
        end else if (m_tick) begin
            m_since++;
            if (m_since >= STALE) m_stale = 1;
        end
        m_tick = last_of_window;
        m_ent  = ent_n;
        m_edges++;
    endtask

    // One clock: advance the model on the edge, compare just after it.
    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        chk("total",   o_total,        m_total[31:0]);
        chk("rate",    32'(o_rate),    32'(m_rate));
        chk("tick",    32'(o_tick),    32'(m_tick));
        chk("stale",   32'(o_stale),   32'(m_stale));
        chk("entropy", 32'(o_ent),     32'(m_ent));
    endtask

    int n;
    bit seen;

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_total", o_total, 32'd0);
        chk("rst_rate",  32'(o_rate), 32'd0);
        chk("rst_tick",  32'(o_tick), 32'd0);
        chk("rst_stale", 32'(o_stale), 32'd0);
        chk("rst_ent",   32'(o_ent), 32'd0);
        rst_n = 1'b1;

        // EMA from zero with two back-to-back identical strobes.
        tv = 1'b1; temp = 12'(BASE + 256);
        cyc();
        cyc();
        tv = 1'b0;
        chk("ema1_ent", 32'(o_ent), 32'd512);
        cyc();
        chk("ema2_ent", 32'(o_ent), 32'd960);

        // Spike count aligned to the start of a window.
        n = 0;
        while ((m_edges % WLEN) != 0 && n < 40) begin cyc(); n++; end
        spk = 8'hFF;
        cyc();
        cyc(); chk("sp8",  o_total, 32'd8);
        cyc(); chk("sp16", o_total, 32'd16); spk = '0;
        cyc(); chk("sp24", o_total, 32'd24);
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            cyc();
            if (o_tick) begin seen = 1; chk("rate24", 32'(o_rate), 32'd24); end
        end
        if (!seen) chk("rate24_timeout", 32'd0, 32'd1);

        // Total wraps modulo 2^32.
        spk = '0; cyc(); cyc();
        force dut.r_total = 32'hFFFF_FFFC;
        #1 release dut.r_total;
        m_total = 64'hFFFF_FFFC;
        spk = 8'h0F;
        cyc();
        cyc(); chk("wrap0", o_total, 32'd0);
        spk = '0;
        cyc(); chk("wrap4", o_total, 32'd4);

        // Stale after four silent windows, with a steady 128/window rate.
        spk = 8'hFF;
        repeat (80) cyc();
        chk("stale_set", 32'(o_stale), 32'd1);
        chk("stale_ent", 32'(o_ent), 32'hFFFF);
        tv = 1'b1; temp = 12'(BASE);
        cyc(); tv = 1'b0;
        chk("stale_clr", 32'(o_stale), 32'd0);
        cyc();
        chk("reseed_ent", 32'(o_ent), 32'd32);

        // Clear on the wrap cycle with all lanes firing.
        n = 0;
        while ((m_edges % WLEN) != (WLEN - 1) && n < 40) begin cyc(); n++; end
        clr = 1'b1; spk = 8'hFF;
        cyc();
        clr = 1'b0;
        chk("clrw_total", o_total, 32'd0);
        chk("clrw_rate",  32'(o_rate), 32'd0);
        chk("clrw_tick",  32'(o_tick), 32'd1);

        // Randomized traffic: dense then sparse temperature strobes.
        for (int i = 0; i < 1500; i++) begin
            spk  = LANES'($urandom) & LANES'($urandom);
            tv   = (i < 700) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 150) == 0);
            temp = TW'($urandom_range(0, 4095));
            clr  = ($urandom_range(0, 120) == 0);
            cyc();
        end
        clr = 1'b0; tv = 1'b0; spk = 8'hFF;
        repeat (5) cyc();

        // Asynchronous reset mid-window.
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_total", o_total, 32'd0);
        chk("arst_rate",  32'(o_rate), 32'd0);
        chk("arst_tick",  32'(o_tick), 32'd0);
        chk("arst_stale", 32'(o_stale), 32'd0);
        chk("arst_ent",   32'(o_ent), 32'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        spk = '0;
        seen = 0; n = 0;
        for (int i = 1; i <= 40 && !seen; i++) begin
            cyc();
            if (o_tick) begin seen = 1; n = i; end
        end
        chk("arst_first_tick", 32'(n), 32'd16);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
